src2_shift_unit: RTL and testbench

Multi-cycle Src2 operand shifter for the datapath; sits between the register-file read and the ALU B input.
- Takes instruction bits 11:0, an immediate flag, register operand Rm and carry-in.
- Produces the shifted/rotated operand plus shifter carry-out.
- Shifts one bit position per cycle under a valid/ready handshake on both sides.

---
 rtl/src2_shift_pkg.sv | 21 ++
 rtl/src2_shift_step.sv | 61 ++++++
 rtl/src2_shift_unit.sv | 160 ++++++++++++++++
 tb/tb_src2_shift_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/src2_shift_pkg.sv
// src2_shift_pkg
// Shared definitions for the Src2 operand shifter: shift-type codes, FSM
// state encoding and the shift counter width.
package src2_shift_pkg;

   // Shift type codes, matching instruction bits 6:5 of the register form.
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   // Counter must hold 32 (LSR/ASR #0 encode a 32-bit shift).
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/src2_shift_step.sv
// src2_shift_step
// Combinational single-bit shift/rotate step used once per SHIFT cycle.
// Ports:
//   value      in   WIDTH  working value before this step
//   sh_type    in   2      SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   rrx        in   1      with SH_ROR: rotate through carry (fill from cin)
//   cin        in   1      carry flag captured at accept, used only for RRX
//   value_next out  WIDTH  value after one step
//   carry      out  1      bit shifted out by this step
module src2_shift_step
   import src2_shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic [1:0]       sh_type,
   input  logic             rrx,
   input  logic             cin,
   output logic [WIDTH-1:0] value_next,
   output logic             carry
);

   logic [WIDTH-1:0] shl;
   logic [WIDTH-2:0] shr_body;
   logic             fill;

   // Bit-wise wiring of the one-position left and right moves.
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bits
         assign shl[gi+1]     = value[gi];
         assign shr_body[gi]  = value[gi+1];
      end
   endgenerate
   assign shl[0] = 1'b0;

   always_comb begin
      fill       = 1'b0;
      value_next = {fill, shr_body};
      carry      = value[0];
      case (sh_type)
         SH_LSL: begin
            value_next = shl;
            carry      = value[WIDTH-1];
         end
         SH_LSR: begin
            fill       = 1'b0;
            value_next = {fill, shr_body};
         end
         SH_ASR: begin
            fill       = value[WIDTH-1];
            value_next = {fill, shr_body};
         end
         default: begin
            // ROR brings bit 0 round to the top; RRX brings in the old carry.
            fill       = rrx ? cin : value[0];
            value_next = {fill, shr_body};
         end
      endcase
   end

endmodule

// File: rtl/src2_shift_unit.sv
// src2_shift_unit
// Multi-cycle Src2 operand shifter between register-file read and ALU B.
// Decodes the immediate / register-shifted-by-constant operand forms and
// shifts one bit position per cycle; register-specified shifts are flagged.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   in_valid   in   1      request present
//   in_ready   out  1      unit idle and able to accept
//   imm        in   1      1 = immediate form, 0 = register-shifted form
//   instr      in   12     instruction bits 11:0
//   rm         in   WIDTH  register operand (ignored when imm=1)
//   cin        in   1      current C flag
//   out_valid  out  1      result available
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  shifted operand
//   cout       out  1      shifter carry-out
//   err        out  1      unsupported encoding, qualified by out_valid
module src2_shift_unit
   import src2_shift_pkg::*;
#(
   parameter int WIDTH = 32   // must be 32: rot*2 and the #32 cases assume it
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             imm,
   input  logic [11:0]      instr,
   input  logic [WIDTH-1:0] rm,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             err
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] val_reg, val_next;
   logic [1:0]       type_reg, type_next;
   logic             rrx_reg, rrx_next;
   logic             cin_reg, cin_next;
   logic             cout_reg, cout_next;
   logic             err_reg, err_next;

   // Decode of the request currently on the input.
   logic [WIDTH-1:0] dec_val;
   logic [1:0]       dec_type;
   logic             dec_rrx;
   logic [CNT_W-1:0] dec_cnt;
   logic             dec_err;
   logic [4:0]       shamt;

   logic [WIDTH-1:0] step_val;
   logic             step_carry;

   assign shamt = instr[11:7];

   always_comb begin
      dec_val  = rm;
      dec_type = instr[6:5];
      dec_rrx  = 1'b0;
      dec_cnt  = {1'b0, shamt};
      dec_err  = 1'b0;
      if (imm) begin
         dec_val  = {{(WIDTH-8){1'b0}}, instr[7:0]};
         dec_type = SH_ROR;
         dec_cnt  = {1'b0, instr[11:8], 1'b0};
      end else if (instr[4]) begin
         // Register-specified shift amount: pass rm through and flag it.
         dec_err = 1'b1;
         dec_cnt = '0;
      end else if (shamt == 5'd0) begin
         case (instr[6:5])
            SH_LSL:  dec_cnt = '0;
            SH_ROR: begin
               dec_rrx = 1'b1;
               dec_cnt = CNT_W'(1);
            end
            default: dec_cnt = CNT_W'(32);   // LSR/ASR #0 encode #32
         endcase
      end
   end

   src2_shift_step #(.WIDTH(WIDTH)) u_step (
      .value      (val_reg),
      .sh_type    (type_reg),
      .rrx        (rrx_reg),
      .cin        (cin_reg),
      .value_next (step_val),
      .carry      (step_carry)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         val_reg   <= '0;
         type_reg  <= SH_LSL;
         rrx_reg   <= 1'b0;
         cin_reg   <= 1'b0;
         cout_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         val_reg   <= val_next;
         type_reg  <= type_next;
         rrx_reg   <= rrx_next;
         cin_reg   <= cin_next;
         cout_reg  <= cout_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      val_next   = val_reg;
      type_next  = type_reg;
      rrx_next   = rrx_reg;
      cin_next   = cin_reg;
      cout_next  = cout_reg;
      err_next   = err_reg;
      case (state_reg)
         S_IDLE: begin
            if (in_valid) begin
               val_next  = dec_val;
               type_next = dec_type;
               rrx_next  = dec_rrx;
               cin_next  = cin;
               cnt_next  = dec_cnt;
               err_next  = dec_err;
               // Zero-count and error cases report the incoming C flag.
               cout_next = cin;
               state_next = (dec_err || dec_cnt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            val_next  = step_val;
            cout_next = step_carry;
            cnt_next  = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_next = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign in_ready  = (state_reg == S_IDLE);
   assign out_valid = (state_reg == S_DONE);
   assign result    = val_reg;
   assign cout      = cout_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_src2_shift_unit.sv
// tb_src2_shift_unit
// Self-checking bench for src2_shift_unit: directed operand cases, error
// path with back-pressure, randomized operations against an arithmetic
// reference model, back-to-back handshake and reset in mid-operation.
module tb_src2_shift_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        imm;
   logic [11:0] instr;
   logic [31:0] rm;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        cout;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int op_num   = 0;

   src2_shift_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .instr     (instr),
      .rm        (rm),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: operand value, carry, error and latency from the
   // architectural shift rules using plain arithmetic.
   function automatic void model(input logic i_imm, input logic [11:0] i_instr,
                                 input logic [31:0] i_rm, input logic i_cin,
                                 output logic [31:0] e_res, output logic e_cout,
                                 output logic e_err, output int e_lat);
      int          n;
      int          s;
      logic [31:0] v;
      logic [63:0] w;
      e_err = 1'b0;
      if (i_imm) begin
         v = {24'd0, i_instr[7:0]};
         n = 2 * int'(i_instr[11:8]);
         if (n == 0) begin
            e_res  = v;
            e_cout = i_cin;
         end else begin
            e_res  = (v >> n) | (v << (32 - n));
            e_cout = e_res[31];
         end
         e_lat = n + 1;
      end else if (i_instr[4]) begin
         e_res  = i_rm;
         e_cout = i_cin;
         e_err  = 1'b1;
         e_lat  = 1;
      end else begin
         s = int'(i_instr[11:7]);
         case (i_instr[6:5])
            2'b00: begin
               if (s == 0) begin
                  e_res  = i_rm;
                  e_cout = i_cin;
               end else begin
                  e_res  = i_rm << s;
                  e_cout = i_rm[32 - s];
               end
               e_lat = s + 1;
            end
            2'b01: begin
               n      = (s == 0) ? 32 : s;
               w      = {32'd0, i_rm} >> n;
               e_res  = w[31:0];
               e_cout = i_rm[n - 1];
               e_lat  = n + 1;
            end
            2'b10: begin
               n      = (s == 0) ? 32 : s;
               w      = {{32{i_rm[31]}}, i_rm} >> n;
               e_res  = w[31:0];
               e_cout = i_rm[n - 1];
               e_lat  = n + 1;
            end
            default: begin
               if (s == 0) begin
                  e_res  = {i_cin, i_rm[31:1]};
                  e_cout = i_rm[0];
                  e_lat  = 2;
               end else begin
                  e_res  = (i_rm >> s) | (i_rm << (32 - s));
                  e_cout = e_res[31];
                  e_lat  = s + 1;
               end
            end
         endcase
      end
   endfunction

   // Present one request, then wait for out_valid; returns what was seen.
   // The result is left pending (out_ready low) for the caller.
   task automatic run_op(input logic i_imm, input logic [11:0] i_instr,
                         input logic [31:0] i_rm, input logic i_cin,
                         output int lat, output logic [31:0] o_res,
                         output logic o_cout, output logic o_err);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      end
      imm      = i_imm;
      instr    = i_instr;
      rm       = i_rm;
      cin      = i_cin;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      o_res  = result;
      o_cout = cout;
      o_err  = err;
      op_num++;
      $display("op %0d imm=%b instr=%03h rm=%08h cin=%b -> result=%08h cout=%b err=%b lat=%0d",
               op_num, i_imm, i_instr, i_rm, i_cin, o_res, o_cout, o_err, lat);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, result, cout, err} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs out_valid=%b result=%08h cout=%b err=%b required 0/0/0/0",
                  out_valid, result, cout, err);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      logic        imm_t   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [11:0] instr_t [5] = '{12'h080, 12'h4FF, 12'h020, 12'h040, 12'h060};
      logic [31:0] rm_t    [5] = '{32'h8000_0001, 32'hDEAD_BEEF, 32'h8000_0000,
                                   32'h8000_0000, 32'h0000_0003};
      logic        cin_t   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] res_t   [5] = '{32'h0000_0002, 32'hFF00_0000, 32'h0000_0000,
                                   32'hFFFF_FFFF, 32'h8000_0001};
      logic        cout_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int          lat_t   [5] = '{2, 9, 33, 33, 2};
      int          lat;
      logic [31:0] r;
      logic        c, e;
      for (int i = 0; i < 5; i++) begin
         run_op(imm_t[i], instr_t[i], rm_t[i], cin_t[i], lat, r, c, e);
         checks++;
         if (r !== res_t[i] || c !== cout_t[i] || e !== 1'b0 || lat != lat_t[i]) begin
            failures++;
            $display("FAIL directed_%0d result=%08h cout=%b err=%b lat=%0d required %08h/%b/0/%0d",
                     i, r, c, e, lat, res_t[i], cout_t[i], lat_t[i]);
         end
         release_out();
      end
   endtask

   task automatic test_err_backpressure();
      int          lat;
      logic [31:0] r;
      logic        c, e;
      logic        c_in = 1'($urandom);
      run_op(1'b0, 12'h010, 32'h1234_5678, c_in, lat, r, c, e);
      checks++;
      if (r !== 32'h1234_5678 || c !== c_in || e !== 1'b1 || lat != 1) begin
         failures++;
         $display("FAIL err_result result=%08h cout=%b err=%b lat=%0d required 12345678/%b/1/1",
                  r, c, e, lat, c_in);
      end
      // A competing request during back-pressure must be ignored.
      imm      = 1'b0;
      instr    = 12'h080;
      rm       = $urandom;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h1234_5678 ||
             cout !== c_in || err !== 1'b1) begin
            failures++;
            $display("FAIL err_hold_%0d out_valid=%b in_ready=%b result=%08h cout=%b err=%b required 1/0/12345678/%b/1",
                     k, out_valid, in_ready, result, cout, err, c_in);
         end
      end
      in_valid = 1'b0;
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL err_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_random();
      int          lat, e_lat;
      logic [31:0] r, e_res, t_rm;
      logic        c, e, e_cout, e_err, t_imm, t_cin;
      logic [11:0] t_instr;
      for (int i = 0; i < 40; i++) begin
         t_imm   = 1'($urandom);
         t_instr = 12'($urandom);
         t_rm    = $urandom;
         t_cin   = 1'($urandom);
         model(t_imm, t_instr, t_rm, t_cin, e_res, e_cout, e_err, e_lat);
         run_op(t_imm, t_instr, t_rm, t_cin, lat, r, c, e);
         checks++;
         if (r !== e_res || c !== e_cout || e !== e_err || lat != e_lat) begin
            failures++;
            $display("FAIL random_%0d result=%08h cout=%b err=%b lat=%0d required %08h/%b/%b/%0d",
                     i, r, c, e, lat, e_res, e_cout, e_err, e_lat);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      int          lat, e_lat;
      logic [31:0] r, e_res, rm_a, rm_b;
      logic        c, e, e_cout, e_err;
      rm_a = $urandom;
      rm_b = $urandom;
      run_op(1'b0, 12'h080, rm_a, 1'b0, lat, r, c, e);
      model(1'b0, 12'h080, rm_a, 1'b0, e_res, e_cout, e_err, e_lat);
      checks++;
      if (r !== e_res || c !== e_cout || lat != e_lat) begin
         failures++;
         $display("FAIL b2b_first result=%08h cout=%b lat=%0d required %08h/%b/%0d",
                  r, c, lat, e_res, e_cout, e_lat);
      end
      // Next request offered in the same cycle the result is taken.
      imm       = 1'b0;
      instr     = 12'h220;          // LSR #4
      rm        = rm_b;
      cin       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done_cycle in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
      run_op(1'b0, 12'h220, rm_b, 1'b1, lat, r, c, e);
      model(1'b0, 12'h220, rm_b, 1'b1, e_res, e_cout, e_err, e_lat);
      checks++;
      if (r !== e_res || c !== e_cout || e !== e_err || lat != e_lat) begin
         failures++;
         $display("FAIL b2b_second result=%08h cout=%b err=%b lat=%0d required %08h/%b/%b/%0d",
                  r, c, e, lat, e_res, e_cout, e_err, e_lat);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      int          lat;
      logic [31:0] r, t_rm;
      logic        c, e;
      imm      = 1'b0;
      instr    = 12'hF80;           // LSL #31
      rm       = 32'hFFFF_FFFF;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'd0 || cout !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid out_valid=%b result=%08h cout=%b in_ready=%b required 0/0/0/1",
                  out_valid, result, cout, in_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      t_rm = $urandom;
      run_op(1'b0, 12'h000, t_rm, 1'b1, lat, r, c, e);
      checks++;
      if (r !== t_rm || c !== 1'b1 || e !== 1'b0 || lat != 1) begin
         failures++;
         $display("FAIL post_reset_lsl0 result=%08h cout=%b err=%b lat=%0d required %08h/1/0/1",
                  r, c, e, lat, t_rm);
      end
      release_out();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      imm       = 1'b0;
      instr     = '0;
      rm        = '0;
      cin       = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_directed();
      test_err_backpressure();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
